// File: rtl/ura_seq_pkg.sv
// Shared types for the URA command sequencer.
//   ura_seq_state_t : sequencer FSM states.
//   ura_cmd_t       : one host command (write flag, address, write data) at the
//                     default URA widths; the RTL packs the same field order
//                     at whatever widths it is built with.
package ura_seq_pkg;

  localparam int URA_ADDR_W = 4;
  localparam int URA_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RSP     = 2'd3
  } ura_seq_state_t;

  typedef struct packed {
    logic                  write;
    logic [URA_ADDR_W-1:0] addr;
    logic [URA_DATA_W-1:0] wdata;
  } ura_cmd_t;

endpackage

// File: rtl/ura_cmd_fifo.sv
// Command buffer for the URA sequencer.
// Ports:
//   clk, rst          clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data   write an entry; ignored while full
//   pop               drop the head entry; ignored while empty
//   head              current head entry (valid when !empty)
//   full, empty       occupancy flags, decoded from the registered count
//   level             number of stored entries
module ura_cmd_fifo
  import ura_seq_pkg::*;
#(
  parameter int WIDTH      = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign level   = count;

  // Storage carries no reset; only occupancy state is cleared.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ura_cmd_sequencer.sv
// Command sequencer in front of the universal register array (URA).
// Host commands are buffered and issued one at a time as single-cycle
// write_en/read_en pulses, gated by URA busy. Read results are returned in
// command order on a valid/ready response channel; no further command issues
// while a response is outstanding.
// Ports:
//   clk, rst                                  clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata   host command channel
//   rsp_valid/rsp_ready/rsp_data              read response channel
//   fifo_level                                buffered, not yet issued commands
//   write_addr/write_data/write_en            URA write port
//   read_addr/read_en/read_data               URA read port
//   busy                                      URA back-pressure on issue
module ura_cmd_sequencer
  import ura_seq_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [DEPTH-1:0]            cmd_addr,
  input  logic [DATA_WIDTH-1:0]       cmd_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [DEPTH-1:0]            write_addr,
  output logic [DATA_WIDTH-1:0]       write_data,
  output logic                        write_en,
  output logic [DEPTH-1:0]            read_addr,
  output logic                        read_en,
  input  logic [DATA_WIDTH-1:0]       read_data,
  input  logic                        busy
);

  localparam int CMD_W = 1 + DEPTH + DATA_WIDTH;
  // Counter only has to hold RD_LATENCY-2 (see ISSUE below).
  localparam int CNT_W = (RD_LATENCY > 2) ? $clog2(RD_LATENCY - 1) : 1;

  logic [CMD_W-1:0]      head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  head_write;
  logic [DEPTH-1:0]      head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;

  ura_seq_state_t        state;
  ura_seq_state_t        state_d;
  logic [CNT_W-1:0]      lat_cnt;
  logic [CNT_W-1:0]      cnt_d;
  logic                  we_d;
  logic                  re_d;
  logic                  rspv_d;
  logic                  capture;

  ura_cmd_fifo #(
    .WIDTH      (CMD_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid),
    .push_data ({cmd_write, cmd_addr, cmd_wdata}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign cmd_ready  = !fifo_full;
  assign head_write = head[CMD_W-1];
  assign head_addr  = head[DATA_WIDTH +: DEPTH];
  assign head_wdata = head[DATA_WIDTH-1:0];

  always_comb begin
    state_d = state;
    cnt_d   = lat_cnt;
    pop     = 1'b0;
    we_d    = 1'b0;
    re_d    = 1'b0;
    rspv_d  = rsp_valid;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !busy) begin
          pop     = 1'b1;
          state_d = ISSUE;
          if (head_write) we_d = 1'b1;
          else            re_d = 1'b1;
        end
      end
      ISSUE: begin
        // The edge leaving ISSUE is already one read-latency edge, so with
        // RD_LATENCY==1 it captures directly; otherwise WAIT_RD counts the
        // remaining RD_LATENCY-1 edges down to 0.
        if (write_en) begin
          state_d = IDLE;
        end else if (RD_LATENCY == 1) begin
          capture = 1'b1;
          rspv_d  = 1'b1;
          state_d = RSP;
        end else begin
          cnt_d   = CNT_W'(RD_LATENCY - 2);
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (lat_cnt == '0) begin
          capture = 1'b1;
          rspv_d  = 1'b1;
          state_d = RSP;
        end else begin
          cnt_d = lat_cnt - 1'b1;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rspv_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- registered outputs / FSM state ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      write_en   <= 1'b0;
      read_en    <= 1'b0;
      rsp_valid  <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      read_addr  <= '0;
      rsp_data   <= '0;
    end else begin
      state     <= state_d;
      lat_cnt   <= cnt_d;
      write_en  <= we_d;
      read_en   <= re_d;
      rsp_valid <= rspv_d;
      if (we_d) begin
        write_addr <= head_addr;
        write_data <= head_wdata;
      end
      if (re_d)    read_addr <= head_addr;
      if (capture) rsp_data  <= read_data;
    end
  end

endmodule
